// File: rtl/count_up16_if.sv
// -----------------------------------------------------------------------------
// count_up16_if -- snapshot handshake bundle for count_up16.
//
// Carries the 4-phase snapshot request/acknowledge pair and the captured
// count value between a requester (master) and the counter (slave).
//   psnap_req : requester -> counter, snapshot request (held until ack rises)
//   psnap_ack : counter -> requester, high while a snapshot is held
//   psnap     : counter -> requester, captured count, stable while psnap_ack=1
// -----------------------------------------------------------------------------
interface count_up16_if #(
  parameter int WIDTH = 16
);
  logic             psnap_req;
  logic             psnap_ack;
  logic [WIDTH-1:0] psnap;

  modport master (
    output psnap_req,
    input  psnap_ack,
    input  psnap
  );

  modport slave (
    input  psnap_req,
    output psnap_ack,
    output psnap
  );
endinterface

// File: rtl/count_up16.sv
// -----------------------------------------------------------------------------
// count_up16 -- loadable up-counter with terminal-count pulse and a
// snapshot port served by a 4-phase handshake.
//
// Ports:
//   pclk   : clock, all state changes on the rising edge
//   prstn  : asynchronous active-low reset
//   pset   : synchronous preset to all ones (highest priority)
//   pld    : synchronous load of pdin
//   pen    : count enable, +1 per cycle
//   pdin   : load value
//   pcnt   : registered count
//   ptc    : registered one-cycle terminal-count pulse
//   snap   : count_up16_if.slave -- psnap_req / psnap_ack / psnap
//
// Configuration:
//   COUNT_UP16_SAT_EN : when defined, an increment at all ones holds the count
//                       at all ones and ptc pulses only on the first such
//                       saturating increment; when undefined the count wraps
//                       to zero and ptc pulses on every wrap.
// -----------------------------------------------------------------------------
module count_up16 #(
  parameter int WIDTH = 16
) (
  input  logic             pclk,
  input  logic             prstn,
  input  logic             pset,
  input  logic             pld,
  input  logic             pen,
  input  logic [WIDTH-1:0] pdin,
  output logic [WIDTH-1:0] pcnt,
  output logic             ptc,
  count_up16_if.slave      snap
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } snap_state_t;

  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] cnt_nxt_s;
  logic             tc_r;
  logic             tc_nxt_s;
  logic [WIDTH-1:0] snap_r;
  logic             ack_r;
  snap_state_t      state_r;

`ifdef COUNT_UP16_SAT_EN
  // Remembers that the count already saturated, so ptc fires only once until
  // the count is rewritten by preset or load.
  logic             seen_r;
  logic             seen_nxt_s;
`endif

  // Next count and terminal-count pulse, priority pset > pld > pen > hold.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    tc_nxt_s   = 1'b0;
`ifdef COUNT_UP16_SAT_EN
    seen_nxt_s = seen_r;
`endif
    if (pset) begin
      cnt_nxt_s  = ALL_ONES;
      tc_nxt_s   = 1'b0;
`ifdef COUNT_UP16_SAT_EN
      seen_nxt_s = 1'b0;
`endif
    end else if (pld) begin
      cnt_nxt_s  = pdin;
      tc_nxt_s   = 1'b0;
`ifdef COUNT_UP16_SAT_EN
      seen_nxt_s = 1'b0;
`endif
    end else if (pen) begin
      if (cnt_r == ALL_ONES) begin
`ifdef COUNT_UP16_SAT_EN
        cnt_nxt_s  = ALL_ONES;
        tc_nxt_s   = ~seen_r;
        seen_nxt_s = 1'b1;
`else
        cnt_nxt_s  = ALL_ZERO;
        tc_nxt_s   = 1'b1;
`endif
      end else begin
        cnt_nxt_s = cnt_r + ONE;
        tc_nxt_s  = 1'b0;
      end
    end else begin
      cnt_nxt_s = cnt_r;
      tc_nxt_s  = 1'b0;
    end
  end

  // Count and terminal-count registers.
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      cnt_r <= ALL_ZERO;
      tc_r  <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      tc_r  <= tc_nxt_s;
    end
  end

`ifdef COUNT_UP16_SAT_EN
  // Saturation-seen flag register.
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      seen_r <= 1'b0;
    end else begin
      seen_r <= seen_nxt_s;
    end
  end
`endif

  // Snapshot handshake FSM; captures the pre-edge count when a request is
  // seen in IDLE and holds it until the request drops.
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      state_r <= IDLE;
      ack_r   <= 1'b0;
      snap_r  <= ALL_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (snap.psnap_req) begin
            snap_r  <= cnt_r;
            ack_r   <= 1'b1;
            state_r <= HELD;
          end else begin
            ack_r   <= 1'b0;
            state_r <= IDLE;
          end
        end
        HELD: begin
          if (!snap.psnap_req) begin
            ack_r   <= 1'b0;
            state_r <= IDLE;
          end else begin
            ack_r   <= 1'b1;
            state_r <= HELD;
          end
        end
        default: begin
          ack_r   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign pcnt           = cnt_r;
  assign ptc            = tc_r;
  assign snap.psnap_ack = ack_r;
  assign snap.psnap     = snap_r;

endmodule

// File: tb/tb_count_up16.sv
// -----------------------------------------------------------------------------
// tb_count_up16 -- self-checking bench for count_up16 (WIDTH=16).
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural model that tracks the count as an integer modulo 2^16.
// Honours COUNT_UP16_SAT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_count_up16;

  localparam int unsigned MOD  = 65536;
  localparam int unsigned MAXV = 65535;

  logic        pclk;
  logic        prstn;
  logic        pset;
  logic        pld;
  logic        pen;
  logic [15:0] pdin;
  logic [15:0] pcnt;
  logic        ptc;

  count_up16_if #(.WIDTH(16)) snap_bus ();

  count_up16 #(.WIDTH(16)) dut (
    .pclk  (pclk),
    .prstn (prstn),
    .pset  (pset),
    .pld   (pld),
    .pen   (pen),
    .pdin  (pdin),
    .pcnt  (pcnt),
    .ptc   (ptc),
    .snap  (snap_bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int unsigned m_cnt  = 0;
  bit          m_tc   = 1'b0;
  bit          m_ack  = 1'b0;
  int unsigned m_snap = 0;
  bit          m_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_tc   = 1'b0;
    m_ack  = 1'b0;
    m_snap = 0;
    m_seen = 1'b0;
  endtask

  // One clock edge of the specified behaviour, evaluated on pre-edge values.
  task automatic model_step(input bit s, input bit l, input bit e,
                            input int unsigned d, input bit r);
    if (!m_ack && r) begin
      m_snap = m_cnt;
      m_ack  = 1'b1;
    end else if (m_ack && !r) begin
      m_ack = 1'b0;
    end
    if (s) begin
      m_cnt = MAXV; m_tc = 1'b0; m_seen = 1'b0;
    end else if (l) begin
      m_cnt = d; m_tc = 1'b0; m_seen = 1'b0;
    end else if (e) begin
`ifdef COUNT_UP16_SAT_EN
      if (m_cnt == MAXV) begin
        m_tc   = !m_seen;
        m_seen = 1'b1;
      end else begin
        m_cnt = m_cnt + 1;
        m_tc  = 1'b0;
      end
`else
      m_tc  = (m_cnt == MAXV);
      m_cnt = (m_cnt + 1) % MOD;
`endif
    end else begin
      m_tc = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pcnt"}, {16'h0, pcnt}, m_cnt);
    check({tag, ".ptc"},  {31'h0, ptc},  {31'h0, m_tc});
    check({tag, ".ack"},  {31'h0, snap_bus.psnap_ack}, {31'h0, m_ack});
    check({tag, ".psnap"}, {16'h0, snap_bus.psnap}, m_snap);
  endtask

  // Drive one cycle from a negedge, step the model at the posedge, check #1 later,
  // and return aligned to the next negedge.
  task automatic do_cycle(input string tag, input bit s, input bit l, input bit e,
                          input logic [15:0] d, input bit r);
    pset = s; pld = l; pen = e; pdin = d; snap_bus.psnap_req = r;
    @(posedge pclk);
    model_step(s, l, e, {16'h0, d}, r);
    #1;
    check_all(tag);
    @(negedge pclk);
  endtask

  // Reset pulse strictly between clock edges; outputs must clear at once.
  task automatic mid_reset(input string tag);
    #2 prstn = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    snap_bus.psnap_req = 1'b0;
    #1 prstn = 1'b1;
  endtask

  bit r_req;

  initial begin
    prstn = 1'b0; pset = 1'b0; pld = 1'b0; pen = 1'b0; pdin = 16'h0;
    snap_bus.psnap_req = 1'b0;
    #1;
    check_all("reset_async");
    repeat (2) @(negedge pclk);
    check_all("reset_held");
    prstn = 1'b1;

    // first edge after reset: enable increments from zero
    do_cycle("first_edge", 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
    check("first_edge.val", {16'h0, pcnt}, 32'h1);

    // load then count
    do_cycle("ld1234", 1'b0, 1'b1, 1'b0, 16'h1234, 1'b0);
    check("ld1234.val", {16'h0, pcnt}, 32'h1234);
    for (int i = 0; i < 3; i++) do_cycle("cnt3", 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
    check("cnt3.val", {16'h0, pcnt}, 32'h1237);

    // priority: all three controls together
    do_cycle("prio", 1'b1, 1'b1, 1'b1, 16'h0042, 1'b0);
    check("prio.val", {16'h0, pcnt}, 32'hFFFF);
    check("prio.tc",  {31'h0, ptc}, 32'h0);
    // pld beats pen
    do_cycle("ld_over_en", 1'b0, 1'b1, 1'b1, 16'h0042, 1'b0);
    // hold
    do_cycle("hold", 1'b0, 1'b0, 1'b0, 16'h9999, 1'b0);
    check("hold.val", {16'h0, pcnt}, 32'h0042);

    // overflow behaviour
    do_cycle("ldFFFE", 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0);
    do_cycle("ovf1", 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
    check("ovf1.val", {16'h0, pcnt}, 32'hFFFF);
    check("ovf1.tc",  {31'h0, ptc}, 32'h0);
    do_cycle("ovf2", 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
`ifdef COUNT_UP16_SAT_EN
    check("ovf2.val", {16'h0, pcnt}, 32'hFFFF);
`else
    check("ovf2.val", {16'h0, pcnt}, 32'h0);
`endif
    check("ovf2.tc", {31'h0, ptc}, 32'h1);
    do_cycle("ovf3", 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
    check("ovf3.tc", {31'h0, ptc}, 32'h0);

    // snapshot handshake while counting
    do_cycle("ld0010", 1'b0, 1'b1, 1'b0, 16'h0010, 1'b0);
    do_cycle("snap_req", 1'b0, 1'b0, 1'b1, 16'h0, 1'b1);
    check("snap_req.snap", {16'h0, snap_bus.psnap}, 32'h0010);
    check("snap_req.ack",  {31'h0, snap_bus.psnap_ack}, 32'h1);
    for (int i = 0; i < 3; i++) do_cycle("snap_hold", 1'b0, 1'b0, 1'b1, 16'h0, 1'b1);
    check("snap_hold.snap", {16'h0, snap_bus.psnap}, 32'h0010);
    do_cycle("snap_drop", 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
    check("snap_drop.ack", {31'h0, snap_bus.psnap_ack}, 32'h0);
    // request raised on the cycle ack fell: served on next edge
    do_cycle("snap_again", 1'b0, 1'b0, 1'b1, 16'h0, 1'b1);
    check("snap_again.ack", {31'h0, snap_bus.psnap_ack}, 32'h1);
    do_cycle("snap_again2", 1'b0, 1'b0, 1'b1, 16'h0, 1'b1);

    // reset between edges while HELD
    mid_reset("mid_reset");
    do_cycle("post_reset", 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    check("post_reset.ack", {31'h0, snap_bus.psnap_ack}, 32'h1);
    do_cycle("post_reset2", 1'b0, 1'b0, 1'b1, 16'h0, 1'b0);

    // randomized traffic, biased to reach the all-ones boundary often
    r_req = 1'b0;
    for (int n = 0; n < 600; n++) begin
      bit s, l, e;
      logic [15:0] d;
      s = ($urandom_range(0, 15) == 0);
      l = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) d = 16'hFFFF - 16'($urandom_range(0, 3));
      else d = 16'($urandom);
      if ($urandom_range(0, 5) == 0) r_req = ~r_req;
      do_cycle("rand", s, l, e, d, r_req);
      if ($urandom_range(0, 149) == 0) begin
        mid_reset("rand_reset");
        r_req = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_up16.md
COUNT_UP16 -- requirements
Module: count_up16

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: counter and data width in bits, legal range 2..32.
REQ-002 The block SHALL have port pclk, input, 1: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port prstn, input, 1: reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port pset, input, 1: synchronous preset; forces the count to all ones.
REQ-005 The block SHALL have port pld, input, 1: synchronous load of pdin.
REQ-006 The block SHALL have port pen, input, 1: count enable; increments by one.
REQ-007 The block SHALL have port pdin, input, WIDTH: load value; pdin[0] is the LSB.
REQ-008 The block SHALL have port pcnt, output, WIDTH: registered count value.
REQ-009 The block SHALL have port ptc, output, 1: registered one-cycle terminal-count pulse.
REQ-010 The block SHALL have port psnap_req, input, 1: snapshot request, 4-phase handshake.
REQ-011 The block SHALL have port psnap_ack, output, 1: snapshot acknowledge.
REQ-012 The block SHALL have port psnap, output, WIDTH: captured count, stable whenever psnap_ack=1.

Function
REQ-013 Per-cycle priority SHALL be pset > pld > pen > hold.
REQ-014 pset=1 SHALL set pcnt to all ones on the next edge; ptc SHALL be 0 that cycle.
REQ-015 pld=1 with pset=0 SHALL set pcnt to pdin on the next edge; ptc SHALL be 0.
REQ-016 pen=1 with pset=0 and pld=0 SHALL set pcnt to pcnt+1 modulo 2^WIDTH on the next edge; latency one cycle.
REQ-017 ptc SHALL be 1 for exactly the cycle after an increment from all ones to zero, and 0 at all other times.
REQ-018 All control inputs low SHALL hold pcnt; ptc SHALL be 0.
REQ-019 The snapshot FSM SHALL have two states: IDLE, with psnap_ack=0, and HELD, with psnap_ack=1.
REQ-020 In IDLE, psnap_req=1 SHALL capture the current pcnt value (before this edge's update) into psnap and move the FSM to HELD.
REQ-021 In HELD, psnap_req=0 SHALL move the FSM to IDLE; psnap SHALL NOT change while in HELD.
REQ-022 A request asserted again on the cycle psnap_ack falls SHALL be served normally on the following IDLE cycle.
REQ-023 Counting SHALL continue unaffected while a snapshot is held.

Reset
REQ-024 prstn=0 SHALL immediately clear pcnt, psnap and ptc to 0, set psnap_ack to 0, and put the FSM in IDLE, regardless of pclk.
REQ-025 Reset asserted mid-handshake SHALL abort the handshake; the requester SHALL re-issue psnap_req after reset.
REQ-026 The first edge after prstn rises SHALL obey REQ-013.

Configuration
REQ-027 Macro COUNT_UP16_SAT_EN SHALL select the overflow behaviour.
REQ-028 With COUNT_UP16_SAT_EN defined, increment at all ones SHALL hold all ones and ptc SHALL pulse once on the first saturating increment only.
REQ-029 With COUNT_UP16_SAT_EN undefined, the count SHALL wrap per REQ-016 and REQ-017.

Verification (WIDTH=16)
REQ-030 Scenario: pld=1, pdin=0x1234, then pen=1 for 3 cycles -> pcnt 0x1234, then 0x1235, 0x1236, 0x1237.
REQ-031 Scenario: pset=1, pld=1, pen=1 in the same cycle -> pcnt=0xFFFF, ptc=0.
REQ-032 Scenario: load 0xFFFE, pen=1 for 2 cycles -> without macro: pcnt 0xFFFF then 0x0000 with ptc=1 for one cycle; with macro: 0xFFFF, 0xFFFF with ptc=1 once.
REQ-033 Scenario: pcnt=0x0010 counting, raise psnap_req -> psnap=0x0010 and psnap_ack=1 next cycle; psnap stays stable while pcnt advances; drop psnap_req -> psnap_ack=0 next cycle.
REQ-034 Scenario: prstn pulsed low between clock edges while in HELD -> pcnt, psnap, ptc and psnap_ack are 0 immediately.
